// File: rtl/serial_ula_pkg.sv
// serial_ula_pkg
// Shared definitions for the bit-serial logic/arithmetic unit:
//   - OP_* : encoding of the 2-bit operation select (AND, OR, ADD, SUB)
//   - state_t : control FSM state type (IDLE, SHIFT, DONE)
//   - is_arith / carry_init : small helpers for carry handling per operation
package serial_ula_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Only ADD and SUB produce a meaningful carry out.
    function automatic logic is_arith(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // SUB is a + ~b + 1, so its carry chain starts at 1.
    function automatic logic carry_init(input logic [1:0] op);
        return (op == OP_SUB);
    endfunction

endpackage

// File: rtl/serial_ula_slice.sv
// serial_slice
// Combinational one-bit slice of the serial unit.
// Ports:
//   ai, bi : current operand bits
//   cin    : registered carry from the previous bit
//   sel    : operation select (OP_AND / OP_OR / OP_ADD / OP_SUB)
//   fi     : result bit
//   cout   : carry into the next bit (0 for AND/OR)
module serial_slice
    import serial_ula_pkg::*;
(
    input  logic       ai,
    input  logic       bi,
    input  logic       cin,
    input  logic [1:0] sel,
    output logic       fi,
    output logic       cout
);

    logic bx;

    always_comb begin
        // SUB inverts b so the same full adder computes a + ~b + c.
        bx   = (sel == OP_SUB) ? ~bi : bi;
        fi   = 1'b0;
        cout = 1'b0;
        case (sel)
            OP_AND:  fi = ai & bi;
            OP_OR:   fi = ai | bi;
            default: begin
                fi   = ai ^ bx ^ cin;
                cout = (ai & bx) | (ai & cin) | (bx & cin);
            end
        endcase
    end

endmodule

// File: rtl/serial_ula.sv
// serial_ula
// Bit-serial AND/OR/ADD/SUB unit. Operands are captured on an accepted
// start and processed one bit per clock, LSB first, through serial_slice.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : begin an operation (honoured only in IDLE)
//   sel   : 00 AND, 01 OR, 10 ADD, 11 SUB (a_in - b_in)
//   a_in  : operand A
//   b_in  : operand B
//   busy  : high for the WIDTH cycles an operation is shifting
//   done  : one-cycle pulse when f/cout take the new result
//   f     : result, held until the next result is published
//   cout  : carry out of the MSB for ADD/SUB, 0 for AND/OR
//
// busy/done/f/cout are registered from the FSM state, so they trail the
// state by one clock: with start sampled at edge N, busy is high after
// edges N+1..N+WIDTH and done/f/cout update at edge N+WIDTH+1. The FSM is
// already back in IDLE during the done cycle, so a new start can be taken
// at the very next edge.
module serial_ula
    import serial_ula_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             cout
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [1:0]       sel_q, sel_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             slice_f;
    logic             slice_c;

    serial_slice u_slice (
        .ai   (a_q[0]),
        .bi   (b_q[0]),
        .cin  (carry_q),
        .sel  (sel_q),
        .fi   (slice_f),
        .cout (slice_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sel_d   = sel_q;
        carry_d = carry_q;
        f_d     = f_q;
        cout_d  = cout_q;
        busy_d  = (state_q == ST_SHIFT);
        done_d  = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    sel_d   = sel;
                    carry_d = carry_init(sel);
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Operands shift right so bit 0 always feeds the slice;
                // results enter at the MSB and settle into place after
                // WIDTH shifts.
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                res_d   = {slice_f, res_q[WIDTH-1:1]};
                carry_d = slice_c;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                f_d     = res_q;
                cout_d  = is_arith(sel_q) ? carry_q : 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sel_q   <= '0;
            carry_q <= 1'b0;
            f_q     <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sel_q   <= sel_d;
            carry_q <= carry_d;
            f_q     <= f_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign f    = f_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_ula.sv
// tb_serial_ula
// Self-checking bench for serial_ula (WIDTH=4): a transaction-level model
// predicts busy/done/f/cout every clock, plus directed operations with
// hand-computed results, mid-operation reset and back-to-back starts.
module tb_serial_ula;

    localparam int W = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   sel;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] f;
    logic         cout;

    int vectors;
    int miscompares;

    // Model state: one operation in flight, tracked by edges since accept.
    bit           m_inflight;
    int           m_age;
    int           m_res_f;
    int           m_res_c;
    bit           m_busy;
    bit           m_done;
    int           m_f;
    int           m_cout;

    serial_ula #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sel   (sel),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .f     (f),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_inflight = 0;
        m_age      = 0;
        m_busy     = 0;
        m_done     = 0;
        m_f        = 0;
        m_cout     = 0;
    endtask

    // Operation result from plain arithmetic.
    task automatic model_compute(input int op, input int a, input int b);
        int s;
        case (op)
            0: begin m_res_f = a & b; m_res_c = 0; end
            1: begin m_res_f = a | b; m_res_c = 0; end
            2: begin s = a + b; m_res_f = s & MASK; m_res_c = (s >> W) & 1; end
            default: begin
                s = a + ((~b) & MASK) + 1;
                m_res_f = s & MASK;
                m_res_c = (s >> W) & 1;
            end
        endcase
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_done = 0;
        if (m_inflight) begin
            m_age++;
            if (m_age <= W) begin
                m_busy = 1;
            end else begin
                m_busy     = 0;
                m_done     = 1;
                m_f        = m_res_f;
                m_cout     = m_res_c;
                m_inflight = 0;
            end
        end else if (start) begin
            model_compute(int'(sel), int'(a_in), int'(b_in));
            m_inflight = 1;
            m_age      = 0;
            m_busy     = 0;
        end
    endtask

    task automatic compare_all();
        checkOutput("busy", int'(busy), int'(m_busy));
        checkOutput("done", int'(done), int'(m_done));
        checkOutput("f",    int'(f),    m_f);
        checkOutput("cout", int'(cout), m_cout);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_inflight && n < 20) begin
            tick();
            n++;
        end
        if (m_inflight) checkOutput("idle_timeout", 0, 1);
    endtask

    // Issue one operation, then check latency and the result literally.
    task automatic applyStimulus(input string name, input logic [1:0] op,
                                 input int a, input int b,
                                 input int exp_f, input int exp_c);
        int lat;
        wait_idle();
        start = 1'b1;
        sel   = op;
        a_in  = W'(a);
        b_in  = W'(b);
        tick();
        start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        checkOutput({name, "_latency"}, lat, W + 1);
        checkOutput({name, "_f"}, int'(f), exp_f);
        checkOutput({name, "_cout"}, int'(cout), exp_c);
    endtask

    initial begin
        int n;
        int got;
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0;
        sel   = 2'b00;
        a_in  = '0;
        b_in  = '0;
        model_reset();

        #1;
        checkOutput("reset_f", int'(f), 0);
        checkOutput("reset_busy", int'(busy), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        applyStimulus("add_7_9", 2'b10, 7, 9, 0, 1);
        applyStimulus("sub_5_3", 2'b11, 5, 3, 2, 1);
        applyStimulus("sub_3_5", 2'b11, 3, 5, 14, 0);
        applyStimulus("and_c_a", 2'b00, 12, 10, 8, 0);
        applyStimulus("or_c_a",  2'b01, 12, 10, 14, 0);
        applyStimulus("add_f_f", 2'b10, 15, 15, 14, 1);
        applyStimulus("sub_0_0", 2'b11, 0, 0, 0, 1);

        // start held high with operands churning while shifting.
        wait_idle();
        start = 1'b1;
        sel   = 2'b10;
        a_in  = 4'd7;
        b_in  = 4'd9;
        tick();
        got = 0;
        for (int i = 0; i < 12; i++) begin
            sel  = 2'($urandom_range(0, 3));
            a_in = W'($urandom);
            b_in = W'($urandom);
            tick();
            if (done) begin
                got = 1;
                break;
            end
        end
        checkOutput("held_done_seen", got, 1);
        checkOutput("held_f", int'(f), 0);
        checkOutput("held_cout", int'(cout), 1);
        sel  = 2'b10;
        a_in = 4'd1;
        b_in = 4'd1;
        tick();
        start = 1'b0;
        tick();
        checkOutput("b2b_busy", int'(busy), 1);
        n = 0;
        while (!done && n < 12) begin
            tick();
            n++;
        end
        checkOutput("b2b_f", int'(f), 2);
        checkOutput("b2b_cout", int'(cout), 0);

        // Reset in the middle of an ADD, while bit 2 is being processed.
        applyStimulus("pre_rst", 2'b11, 5, 3, 2, 1);
        start = 1'b1;
        sel   = 2'b10;
        a_in  = 4'd7;
        b_in  = 4'd9;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        checkOutput("rst_async_f", int'(f), 0);
        checkOutput("rst_async_cout", int'(cout), 0);
        checkOutput("rst_async_busy", int'(busy), 0);
        checkOutput("rst_async_done", int'(done), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < W + 3; i++) begin
            tick();
        end
        applyStimulus("add_1_1", 2'b10, 1, 1, 2, 0);

        // Random traffic; the model checks every cycle.
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 2) == 0);
            sel   = 2'($urandom_range(0, 3));
            a_in  = W'($urandom);
            b_in  = W'($urandom);
            tick();
        end
        start = 1'b0;
        wait_idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
